run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor_pkg.sv | 18 +
 rtl/run_monitor.sv | 87 ++++++++
 tb/tb_run_monitor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run monitor: FSM states and the stop-instruction
// encodings that the core's decoder also recognises.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;  // jal x0,0
  localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;  // ecall

  function automatic logic is_stop(input logic vld, input logic [31:0] word);
    return vld && ((word == INSTR_JAL_SELF) || (word == INSTR_ECALL));
  endfunction

endpackage

// File: rtl/run_monitor.sv
// Watches the core for a stop instruction or cycle-budget expiry, then halts it
// and streams the architectural register file out over a valid/ready port.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [31:0]             instr,
  output logic                    halt,
  output logic [$clog2(NREG)-1:0] reg_rd_addr,
  input  logic [XLEN-1:0]         reg_rd_data,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [$clog2(NREG)-1:0] dump_index,
  output logic [XLEN-1:0]         dump_data,
  output logic [XLEN-1:0]         cycle_count,
  output logic                    timeout,
  output logic                    completed
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0]   LAST_IDX   = AW'(NREG - 1);
  localparam logic [XLEN-1:0] LAST_CYCLE = XLEN'(MAX_CYCLES - 1);

  state_e state, state_n;
  logic   stop_evt;
  logic   budget_hit;
  logic   beat_xfer;
  logic   halt_q;

  assign stop_evt   = is_stop(instr_valid, instr);
  assign budget_hit = (cycle_count == LAST_CYCLE);
  assign beat_xfer  = (state == DUMP) && dump_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // A stop event wins over the budget; both leave RUN on the next edge.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (stop_evt || budget_hit) state_n = DUMP;
      DUMP:    if (beat_xfer && (dump_index == LAST_IDX)) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      dump_index  <= '0;
      timeout     <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cycle_count <= cycle_count + XLEN'(1);
          if (state_n == DUMP) begin
            halt_q     <= 1'b1;
            timeout    <= !stop_evt;
            dump_index <= '0;
          end
        end
        DUMP: begin
          if (beat_xfer && (dump_index != LAST_IDX)) dump_index <= dump_index + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // The combinational term stops the core before the stopping instruction retires.
  assign halt        = halt_q || ((state == RUN) && stop_evt);
  assign dump_valid  = (state == DUMP);
  assign completed   = (state == DONE);
  assign reg_rd_addr = dump_index;
  assign dump_data   = (dump_index == '0) ? '0 : reg_rd_data;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: scenario tasks with a beat scoreboard.
module tb_run_monitor;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic        dump_ready = 1'b0;
  logic        halt, dump_valid, timeout, completed;
  logic [4:0]  reg_rd_addr, dump_index;
  logic [31:0] reg_rd_data, dump_data, cycle_count;

  logic [31:0] regs [NREG];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  run_monitor #(.XLEN(XLEN), .NREG(NREG), .MAX_CYCLES(MAXC)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .halt        (halt),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_index  (dump_index),
    .dump_data   (dump_data),
    .cycle_count (cycle_count),
    .timeout     (timeout),
    .completed   (completed)
  );

  always #5 clk = ~clk;

  assign reg_rd_data = regs[reg_rd_addr];

  task automatic load_regs(input bit ramp);
    for (int i = 0; i < NREG; i++) regs[i] = ramp ? ((i == 0) ? 32'd7 : 32'(i)) : $urandom;
  endtask

  task automatic push_dump();
    beat_t b;
    for (int i = 0; i < NREG; i++) begin
      b.idx  = 5'(i);
      b.data = (i == 0) ? 32'd0 : regs[i];
      sb.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b0; dump_ready = 1'b0; instr = 32'h0000_0013;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL %s_halt: got %b expected 0", tag, halt); end
    n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL %s_dump_valid: got %b expected 0", tag, dump_valid); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %b expected 0", tag, timeout); end
    n_checks++; if (completed !== 1'b0) begin n_fail++; $display("FAIL %s_completed: got %b expected 0", tag, completed); end
    n_checks++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL %s_cycle_count: got %0d expected 0", tag, cycle_count); end
    n_checks++; if (dump_index !== 5'd0) begin n_fail++; $display("FAIL %s_dump_index: got %0d expected 0", tag, dump_index); end
    n_checks++; if (reg_rd_addr !== 5'd0) begin n_fail++; $display("FAIL %s_reg_rd_addr: got %0d expected 0", tag, reg_rd_addr); end
  endtask

  // Drive non-stop instruction traffic until cycle_count reaches target.
  task automatic run_until(input int target);
    int guard = 0;
    while (cycle_count !== 32'(target) && guard < 200) begin
      case (guard % 6)
        0:       begin instr_valid = 1'b1; instr = 32'h0000_0013; end
        1:       begin instr_valid = 1'b0; instr = 32'h0000_006F; end
        2:       begin instr_valid = 1'b0; instr = 32'h0000_0073; end
        3:       begin instr_valid = 1'b1; instr = 32'h0000_106F; end
        4:       begin instr_valid = 1'b1; instr = 32'h0010_0073; end
        default: begin instr_valid = 1'b1; instr = 32'h0000_006E; end
      endcase
      #1;
      n_checks++;
      if (halt !== 1'b0) begin
        n_fail++; $display("FAIL halt_nonstop: got %b expected 0 (valid=%b instr=%h)", halt, instr_valid, instr);
      end
      @(negedge clk);
      guard++;
    end
    instr_valid = 1'b0; instr = 32'h0000_0013;
    n_checks++;
    if (cycle_count !== 32'(target)) begin
      n_fail++; $display("FAIL run_until: cycle_count got %0d expected %0d", cycle_count, target);
    end
  endtask

  task automatic stop_at(input int target, input logic [31:0] word);
    run_until(target);
    instr_valid = 1'b1; instr = word;
    #1;
    n_checks++; if (halt !== 1'b1) begin n_fail++; $display("FAIL stop_halt_comb: got %b expected 1", halt); end
    n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL stop_dump_valid_early: got %b expected 0", dump_valid); end
    push_dump();
    @(negedge clk);
    instr_valid = 1'b0; instr = 32'h0000_0013;
    n_checks++; if (cycle_count !== 32'(target + 1)) begin n_fail++; $display("FAIL stop_cycle_count: got %0d expected %0d", cycle_count, target + 1); end
    n_checks++; if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL stop_enter_dump: got %b expected 1", dump_valid); end
    n_checks++; if (dump_index !== 5'd0) begin n_fail++; $display("FAIL stop_first_index: got %0d expected 0", dump_index); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL stop_timeout: got %b expected 0", timeout); end
    n_checks++; if (halt !== 1'b1) begin n_fail++; $display("FAIL stop_halt_reg: got %b expected 1", halt); end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic collect_dump(input int mode, input logic exp_to, input logic [31:0] exp_cc, input int max_beats);
    int    beats = 0;
    int    cyc = 0;
    int    m = max_beats - 1;
    int    exp_cyc;
    bit    holding = 1'b0;
    bit    r;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    beat_t e;
    exp_cyc = (mode == 0) ? max_beats : ((m % 2 == 1) ? 2 * m + 2 : 2 * m + 1);
    while (beats < max_beats && cyc < 8 * NREG) begin
      n_checks++;
      if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL dump_valid: got %b expected 1 at cycle %0d", dump_valid, cyc); end
      n_checks++;
      if (cycle_count !== exp_cc || timeout !== exp_to || halt !== 1'b1 || completed !== 1'b0) begin
        n_fail++;
        $display("FAIL dump_status: got cc=%0d to=%b halt=%b done=%b expected cc=%0d to=%b halt=1 done=0",
                 cycle_count, timeout, halt, completed, exp_cc, exp_to);
      end
      if (holding) begin
        n_checks++;
        if (dump_index !== h_idx || dump_data !== h_data) begin
          n_fail++; $display("FAIL stall_hold: got idx=%0d data=%h expected idx=%0d data=%h", dump_index, dump_data, h_idx, h_data);
        end
      end
      r = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      dump_ready = r;
      if (r) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL scoreboard_empty: got beat idx=%0d expected none", dump_index);
        end else begin
          e = sb.pop_front();
          if (dump_index !== e.idx || dump_data !== e.data) begin
            n_fail++; $display("FAIL beat: got idx=%0d data=%h expected idx=%0d data=%h", dump_index, dump_data, e.idx, e.data);
          end
        end
        beats++;
        holding = 1'b0;
      end else begin
        holding = 1'b1; h_idx = dump_index; h_data = dump_data;
      end
      cyc++;
      @(negedge clk);
    end
    dump_ready = 1'b0;
    n_checks++;
    if (beats != max_beats || cyc != exp_cyc) begin
      n_fail++; $display("FAIL dump_timing: got %0d beats in %0d cycles expected %0d in %0d", beats, cyc, max_beats, exp_cyc);
    end
    if (max_beats == NREG) begin
      n_checks++;
      if (completed !== 1'b1 || dump_valid !== 1'b0 || halt !== 1'b1) begin
        n_fail++; $display("FAIL done_flags: got done=%b valid=%b halt=%b expected 1 0 1", completed, dump_valid, halt);
      end
      n_checks++; if (timeout !== exp_to) begin n_fail++; $display("FAIL done_timeout: got %b expected %b", timeout, exp_to); end
      n_checks++; if (cycle_count !== exp_cc) begin n_fail++; $display("FAIL done_cycle_count: got %0d expected %0d", cycle_count, exp_cc); end
      n_checks++; if (dump_index !== 5'(NREG - 1)) begin n_fail++; $display("FAIL done_index_wrap: got %0d expected %0d", dump_index, NREG - 1); end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d beats pending expected 0", sb.size()); end
    end
  endtask

  task automatic done_hold(input logic [31:0] exp_cc, input logic exp_to);
    instr_valid = 1'b1; instr = 32'h0000_0073; dump_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (completed !== 1'b1 || dump_valid !== 1'b0 || halt !== 1'b1 || cycle_count !== exp_cc || timeout !== exp_to) begin
      n_fail++;
      $display("FAIL done_hold: got done=%b valid=%b halt=%b cc=%0d to=%b expected 1 0 1 %0d %b",
               completed, dump_valid, halt, cycle_count, timeout, exp_cc, exp_to);
    end
    instr_valid = 1'b0; instr = 32'h0000_0013; dump_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cycle_count !== 32'd1) begin n_fail++; $display("FAIL reset_first_count: got %0d expected 1", cycle_count); end
  endtask

  task automatic test_stop_jal();
    do_reset();
    load_regs(1'b1);
    stop_at(10, 32'h0000_006F);
    collect_dump(0, 1'b0, 32'd11, NREG);
    done_hold(32'd11, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    load_regs(1'b0);
    run_until(MAXC - 1);
    n_checks++; if (dump_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got valid=%b to=%b expected 0 0", dump_valid, timeout); end
    push_dump();
    @(negedge clk);
    n_checks++; if (cycle_count !== 32'(MAXC)) begin n_fail++; $display("FAIL timeout_cycle_count: got %0d expected %0d", cycle_count, MAXC); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b expected 1", timeout); end
    n_checks++; if (dump_valid !== 1'b1 || halt !== 1'b1) begin n_fail++; $display("FAIL timeout_enter_dump: got valid=%b halt=%b expected 1 1", dump_valid, halt); end
    collect_dump(0, 1'b1, 32'(MAXC), NREG);
  endtask

  task automatic test_stall();
    do_reset();
    load_regs(1'b0);
    dump_ready = 1'b1;
    stop_at(3, 32'h0000_0073);
    collect_dump(1, 1'b0, 32'd4, NREG);
    done_hold(32'd4, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    do_reset();
    load_regs(1'b0);
    stop_at(6, 32'h0000_006F);
    collect_dump(0, 1'b0, 32'd7, 12);
    n_checks++; if (dump_index !== 5'd12 || dump_valid !== 1'b1) begin n_fail++; $display("FAIL mid_dump_beat12: got idx=%0d valid=%b expected 12 1", dump_index, dump_valid); end
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cycle_count !== 32'd1 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_run: got cc=%0d valid=%b expected 1 0", cycle_count, dump_valid); end
    load_regs(1'b0);
    stop_at(5, 32'h0000_0073);
    collect_dump(0, 1'b0, 32'd6, NREG);
  endtask

  task automatic test_same_cycle();
    do_reset();
    load_regs(1'b0);
    stop_at(MAXC - 1, 32'h0000_006F);
    collect_dump(0, 1'b0, 32'(MAXC), NREG);
  endtask

  initial begin
    test_reset();
    test_stop_jal();
    test_timeout();
    test_stall();
    test_reset_mid_dump();
    test_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
